// File: rtl/phase_center_subtract.sv
// phase_center_subtract: subtracts a per-channel center, loaded through a register word, from a phase stream.
// Define PHASE_CENTER_SAT_EN to saturate the result instead of wrapping it modulo 2^DATA_W.
module phase_center_subtract #(
  parameter int CH_BITS = 8,
  parameter int DATA_W  = 16
) (
  input  logic               user_clk,
  input  logic               user_rst_n,
  input  logic [31:0]        reg_data,
  input  logic [DATA_W-1:0]  phase_in,
  input  logic [CH_BITS-1:0] phase_ch,
  input  logic               phase_valid,
  output logic [DATA_W-1:0]  phase_out,
  output logic [CH_BITS-1:0] phase_out_ch,
  output logic               phase_out_valid,
  output logic               table_ready,
  output logic [15:0]        load_count
);
  typedef enum logic [1:0] {CLEAR, IDLE, WRITE} state_t;
  state_t r_state, w_next;
  logic [DATA_W-1:0]  r_mem [2**CH_BITS];
  logic [CH_BITS-1:0] r_clr_addr, r_pend_addr, r_ch1, w_waddr;
  logic [DATA_W-1:0]  r_pend_data, r_ph1, r_cen1, w_wdata, w_cen, w_res;
  logic [DATA_W:0]    w_diff;
  logic               r_flag_d, r_pend, r_v1, r_rdy1, w_req, w_we, w_unused;
  assign w_unused    = ^reg_data[30:0];
  assign w_req       = reg_data[31] & ~r_flag_d;
  assign table_ready = r_state != CLEAR;
  always_ff @(posedge user_clk or negedge user_rst_n)
    if (!user_rst_n) r_state <= CLEAR;
    else             r_state <= w_next;
  always_comb begin
    w_next  = r_state;
    w_we    = 1'b0;
    w_waddr = r_clr_addr;
    w_wdata = '0;
    case (r_state)
      CLEAR: begin
        w_we = 1'b1;
        if (&r_clr_addr) w_next = IDLE;
      end
      IDLE: if (r_pend) w_next = WRITE;
      WRITE: begin
        w_we    = 1'b1;
        w_waddr = r_pend_addr;
        w_wdata = r_pend_data;
        w_next  = IDLE;
      end
      default: w_next = CLEAR;
    endcase
  end
  // A request landing in the WRITE cycle survives the clear of the one being written.
  always_ff @(posedge user_clk or negedge user_rst_n)
    if (!user_rst_n) begin
      r_clr_addr  <= '0;
      r_flag_d    <= 1'b1;
      r_pend      <= 1'b0;
      r_pend_addr <= '0;
      r_pend_data <= '0;
      load_count  <= '0;
    end else begin
      r_flag_d <= reg_data[31];
      if (r_state == CLEAR) r_clr_addr <= r_clr_addr + 1'b1;
      if (r_state == WRITE) load_count <= load_count + 16'd1;
      if (w_req) begin
        r_pend      <= 1'b1;
        r_pend_addr <= reg_data[16 +: CH_BITS];
        r_pend_data <= reg_data[DATA_W-1:0];
      end else if (r_state == WRITE) r_pend <= 1'b0;
    end
  always_ff @(posedge user_clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
    r_cen1 <= r_mem[phase_ch];
  end
  assign w_cen  = r_rdy1 ? r_cen1 : '0;
  assign w_diff = {r_ph1[DATA_W-1], r_ph1} - {w_cen[DATA_W-1], w_cen};
`ifdef PHASE_CENTER_SAT_EN
  assign w_res = (w_diff[DATA_W] == w_diff[DATA_W-1]) ? w_diff[DATA_W-1:0]
               : {w_diff[DATA_W], {(DATA_W-1){~w_diff[DATA_W]}}};
`else
  assign w_res = w_diff[DATA_W-1:0];
`endif
  always_ff @(posedge user_clk or negedge user_rst_n)
    if (!user_rst_n) begin
      r_v1            <= 1'b0;
      r_rdy1          <= 1'b0;
      r_ph1           <= '0;
      r_ch1           <= '0;
      phase_out_valid <= 1'b0;
      phase_out       <= '0;
      phase_out_ch    <= '0;
    end else begin
      r_v1            <= phase_valid;
      r_rdy1          <= table_ready;
      phase_out_valid <= r_v1;
      if (phase_valid) begin
        r_ph1 <= phase_in;
        r_ch1 <= phase_ch;
      end
      if (r_v1) begin
        phase_out    <= w_res;
        phase_out_ch <= r_ch1;
      end
    end
endmodule
